// File: rtl/counter_seq.sv
// counter_seq: command front-end and sequencer for the 16-bit up/down counter.
// Accepts START/STOP/CLEAR over valid/ready, strobes load/clear/count-enable,
// paces counting with a prescaler and stops or reloads at terminal count.
// Optional sticky interrupt: define COUNTER_SEQ_IRQ_EN to enable o_irq.
module counter_seq #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  i_sysclk,
   input  logic                  i_sysrst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [1:0]            i_cmd_op,
   input  logic [15:0]           i_cmd_load,
   input  logic                  i_cmd_dir,
   input  logic                  i_cmd_periodic,
   input  logic [PRESCALE_W-1:0] i_cmd_prescale,
   input  logic [15:0]           i_cnt,
   output logic                  o_ld,
   output logic [15:0]           o_ld_data,
   output logic                  o_clr,
   output logic                  o_cnt_en,
   output logic                  o_dir,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_irq,
   input  logic                  i_irq_ack
);

   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      load_q;
   logic                  dir_q;
   logic                  periodic_q;
   logic [PRESCALE_W-1:0] presc_q;
   logic [PRESCALE_W-1:0] presc_cnt_q;
   logic                  clr_q;
   logic                  clr_d;
   logic                  start_c;
   logic                  tick_c;
   logic                  ready_c;
   logic                  fire_c;
   logic                  term_c;
   logic [CNT_W-1:0]      term_val_c;

   // Command handshake and terminal-count detect
   assign ready_c    = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign fire_c     = i_cmd_valid && ready_c;
   assign term_val_c = dir_q ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
   assign term_c     = (i_cnt == term_val_c);

   // State and clear-strobe registers
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         state_q <= ST_IDLE;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   // Next-state, command decode and count pacing
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      start_c = 1'b0;
      tick_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fire_c) begin
               case (i_cmd_op)
                  OP_START: begin
                     start_c = 1'b1;
                     state_d = ST_LOAD;
                  end
                  OP_CLEAR: clr_d = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            // Step on the first RUN cycle, then once per (prescale+1) cycles
            tick_c = !term_c && (presc_cnt_q == '0);
            if (fire_c && (i_cmd_op != OP_RSVD)) begin
               case (i_cmd_op)
                  OP_START: begin
                     start_c = 1'b1;
                     state_d = ST_LOAD;
                  end
                  OP_STOP: state_d = ST_IDLE;
                  default: begin
                     clr_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               endcase
            end else if (term_c) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = periodic_q ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler: cleared on START and on every load, wraps at the latched value
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         presc_cnt_q <= '0;
      end else if (start_c || (state_q == ST_LOAD)) begin
         presc_cnt_q <= '0;
      end else if ((state_q == ST_RUN) && !term_c) begin
         presc_cnt_q <= (presc_cnt_q == presc_q) ? '0 : presc_cnt_q + PRESCALE_W'(1);
      end
   end

   // START parameter latch
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         load_q     <= '0;
         dir_q      <= 1'b0;
         periodic_q <= 1'b0;
         presc_q    <= '0;
      end else if (start_c) begin
         load_q     <= i_cmd_load;
         dir_q      <= i_cmd_dir;
         periodic_q <= i_cmd_periodic;
         presc_q    <= i_cmd_prescale;
      end
   end

`ifdef COUNTER_SEQ_IRQ_EN
   logic irq_q;

   // Sticky terminal interrupt; a DONE cycle wins over a same-cycle ack
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         irq_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
         irq_q <= 1'b1;
      end else if (i_irq_ack) begin
         irq_q <= 1'b0;
      end
   end

   assign o_irq = irq_q;
`else
   logic unused_irq_ack;

   assign unused_irq_ack = i_irq_ack;
   assign o_irq          = 1'b0;
`endif

   // Strobes decoded from registered state
   assign o_cmd_ready = ready_c;
   assign o_ld        = (state_q == ST_LOAD);
   assign o_done      = (state_q == ST_DONE);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_clr       = clr_q;
   assign o_cnt_en    = tick_c;
   assign o_ld_data   = load_q;
   assign o_dir       = dir_q;

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: directed table, hand sequences and randomized run of
// counter_seq against a cycle-offset reference model and a behavioural counter.
module tb_counter_seq;

`ifdef COUNTER_SEQ_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        i_sysclk       = 1'b0;
   logic        i_sysrst_n     = 1'b0;
   logic        i_cmd_valid    = 1'b0;
   logic        o_cmd_ready;
   logic [1:0]  i_cmd_op       = 2'b00;
   logic [15:0] i_cmd_load     = 16'h0000;
   logic        i_cmd_dir      = 1'b0;
   logic        i_cmd_periodic = 1'b0;
   logic [7:0]  i_cmd_prescale = 8'h00;
   logic [15:0] cnt;
   logic        o_ld;
   logic [15:0] o_ld_data;
   logic        o_clr;
   logic        o_cnt_en;
   logic        o_dir;
   logic        o_busy;
   logic        o_done;
   logic        o_irq;
   logic        i_irq_ack      = 1'b0;

   int checks = 0;
   int errors = 0;

   counter_seq #(.PRESCALE_W(8)) dut (
      .i_sysclk      (i_sysclk),
      .i_sysrst_n    (i_sysrst_n),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_op      (i_cmd_op),
      .i_cmd_load    (i_cmd_load),
      .i_cmd_dir     (i_cmd_dir),
      .i_cmd_periodic(i_cmd_periodic),
      .i_cmd_prescale(i_cmd_prescale),
      .i_cnt         (cnt),
      .o_ld          (o_ld),
      .o_ld_data     (o_ld_data),
      .o_clr         (o_clr),
      .o_cnt_en      (o_cnt_en),
      .o_dir         (o_dir),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_irq         (o_irq),
      .i_irq_ack     (i_irq_ack)
   );

   always #5 i_sysclk = ~i_sysclk;

   // Behavioural 16-bit up/down counter driven by the sequencer strobes
   always @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n)   cnt <= 16'h0000;
      else if (o_clr)    cnt <= 16'h0000;
      else if (o_ld)     cnt <= o_ld_data;
      else if (o_cnt_en) cnt <= o_dir ? cnt + 16'd1 : cnt - 16'd1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_sysclk);
      #1;
   endtask

   task automatic do_reset();
      i_cmd_valid = 1'b0;
      i_irq_ack   = 1'b0;
      i_sysrst_n  = 1'b0;
      cyc();
      cyc();
      @(negedge i_sysclk);
      i_sysrst_n = 1'b1;
      cyc();
   endtask

   // Present a command, hold until accepted (bounded), return in the cycle after acceptance
   task automatic send(input logic [1:0] op, input logic [15:0] ld, input logic dir,
                       input logic per, input logic [7:0] p);
      int n;
      n = 0;
      i_cmd_valid    = 1'b1;
      i_cmd_op       = op;
      i_cmd_load     = ld;
      i_cmd_dir      = dir;
      i_cmd_periodic = per;
      i_cmd_prescale = p;
      while (!o_cmd_ready && n < 50) begin
         cyc();
         n++;
      end
      check_b("send_ready", o_cmd_ready, 1'b1);
      cyc();
      i_cmd_valid = 1'b0;
   endtask

   typedef struct {
      logic [15:0] load;
      logic        dir;
      logic [7:0]  p;
      int          exp_done;   // cycles from o_ld to o_done
      int          exp_steps;  // number of o_cnt_en pulses
      int          exp_final;  // counter value once idle
   } vec_t;

   vec_t vecs[7];

   // Reference model state for the random phase
   bit          m_active;
   int          m_l;
   logic [15:0] m_load;
   logic        m_dir;
   logic        m_per;
   int          m_p;
   int          m_clr_at;
   bit          m_irq;

   initial begin
      vecs[0] = '{16'hFFFD, 1'b1, 8'd0,  4,  2, 'hFFFF};
      vecs[1] = '{16'h0003, 1'b0, 8'd2,  9,  3, 'h0000};
      vecs[2] = '{16'h0000, 1'b0, 8'd5,  2,  0, 'h0000};
      vecs[3] = '{16'hFFFF, 1'b1, 8'd3,  2,  0, 'hFFFF};
      vecs[4] = '{16'hFFF0, 1'b1, 8'd1, 31, 15, 'hFFFF};
      vecs[5] = '{16'h000A, 1'b0, 8'd0, 12, 10, 'h0000};
      vecs[6] = '{16'h0002, 1'b0, 8'd7, 11,  2, 'h0000};

      // Reset state
      do_reset();
      check_b("rst_ready", o_cmd_ready, 1'b1);
      check_b("rst_busy", o_busy, 1'b0);
      check_b("rst_ld", o_ld, 1'b0);
      check_b("rst_irq", o_irq, 1'b0);

      // Reset asserted mid-RUN takes effect without a clock edge
      send(2'b00, 16'h1000, 1'b1, 1'b0, 8'd0);
      cyc();
      cyc();
      check_b("mid_run_busy", o_busy, 1'b1);
      check_b("mid_run_en", o_cnt_en, 1'b1);
      i_sysrst_n = 1'b0;
      #2;
      check_b("arst_ld", o_ld, 1'b0);
      check_b("arst_clr", o_clr, 1'b0);
      check_b("arst_en", o_cnt_en, 1'b0);
      check_b("arst_done", o_done, 1'b0);
      check_b("arst_busy", o_busy, 1'b0);
      check_b("arst_ready", o_cmd_ready, 1'b1);
      check_b("arst_irq", o_irq, 1'b0);
      check_b("arst_dir", o_dir, 1'b0);
      check_i("arst_ld_data", int'(o_ld_data), 0);
      @(negedge i_sysclk);
      i_sysrst_n = 1'b1;
      cyc();

      // One-shot up from FFFD, prescale 0: exact cycle placement
      send(2'b00, 16'hFFFD, 1'b1, 1'b0, 8'd0);
      check_b("a_ld_n1", o_ld, 1'b1);
      check_b("a_ready_n1", o_cmd_ready, 1'b0);
      check_b("a_en_n1", o_cnt_en, 1'b0);
      cyc();
      check_b("a_en_n2", o_cnt_en, 1'b1);
      check_i("a_cnt_n2", int'(cnt), 'hFFFD);
      cyc();
      check_b("a_en_n3", o_cnt_en, 1'b1);
      cyc();
      check_b("a_en_n4", o_cnt_en, 1'b0);
      check_i("a_cnt_n4", int'(cnt), 'hFFFF);
      check_b("a_done_n4", o_done, 1'b0);
      cyc();
      check_b("a_done_n5", o_done, 1'b1);
      check_b("a_ready_n5", o_cmd_ready, 1'b0);
      cyc();
      check_b("a_done_n6", o_done, 1'b0);
      check_b("a_busy_n6", o_busy, 1'b0);
      check_i("a_cnt_n6", int'(cnt), 'hFFFF);
      check_b("a_irq_oneshot", o_irq, IRQ_EN);

      // Periodic down from 3, prescale 2: two full rounds, ack during second DONE
      send(2'b00, 16'h0003, 1'b0, 1'b1, 8'd2);
      for (int d = 0; d <= 20; d++) begin
         int  r;
         logic e_en;
         r    = d % 10;
         e_en = (r >= 1) && (r < 8) && (((r - 1) % 3) == 0);
         check_b("b_ld", o_ld, (r == 0));
         check_b("b_en", o_cnt_en, e_en);
         check_b("b_done", o_done, (r == 9));
         if (d == 19) i_irq_ack = 1'b1;
         if (d < 20) cyc();
         i_irq_ack = 1'b0;
      end
      check_b("b_irq_ack_in_done", o_irq, IRQ_EN);
      send(2'b01, 16'h0000, 1'b0, 1'b0, 8'd0);
      check_b("b_stop_busy", o_busy, 1'b0);
      i_irq_ack = 1'b1;
      cyc();
      i_irq_ack = 1'b0;
      check_b("b_irq_ack_clear", o_irq, 1'b0);

      // STOP at count 5 holds the value; CLEAR then zeroes it
      send(2'b00, 16'h0006, 1'b0, 1'b0, 8'd3);
      cyc();
      check_i("c_cnt_d1", int'(cnt), 'h6);
      check_b("c_en_d1", o_cnt_en, 1'b1);
      cyc();
      check_i("c_cnt_d2", int'(cnt), 'h5);
      check_b("c_en_d2", o_cnt_en, 1'b0);
      send(2'b01, 16'h0000, 1'b0, 1'b0, 8'd0);
      check_b("c_stop_busy", o_busy, 1'b0);
      check_b("c_stop_en", o_cnt_en, 1'b0);
      cyc();
      cyc();
      cyc();
      check_i("c_held", int'(cnt), 'h5);
      send(2'b10, 16'h0000, 1'b0, 1'b0, 8'd0);
      check_b("c_clr", o_clr, 1'b1);
      check_b("c_clr_ld", o_ld, 1'b0);
      check_b("c_clr_busy", o_busy, 1'b0);
      cyc();
      check_b("c_clr_one", o_clr, 1'b0);
      check_i("c_cleared", int'(cnt), 0);

      // Load equal to terminal: o_done two cycles after o_ld
      send(2'b00, 16'h0000, 1'b0, 1'b0, 8'd0);
      check_b("d_ld", o_ld, 1'b1);
      cyc();
      check_b("d_run_en", o_cnt_en, 1'b0);
      check_b("d_run_busy", o_busy, 1'b1);
      check_b("d_run_done", o_done, 1'b0);
      cyc();
      check_b("d_done", o_done, 1'b1);
      cyc();
      check_b("d_idle", o_busy, 1'b0);

      // START presented during LOAD is held off until RUN
      send(2'b00, 16'h0100, 1'b1, 1'b0, 8'd0);
      i_cmd_valid    = 1'b1;
      i_cmd_op       = 2'b00;
      i_cmd_load     = 16'h0003;
      i_cmd_dir      = 1'b0;
      i_cmd_periodic = 1'b0;
      i_cmd_prescale = 8'd0;
      check_b("e_ready_load", o_cmd_ready, 1'b0);
      cyc();
      check_b("e_run_ld", o_ld, 1'b0);
      check_b("e_ready_run", o_cmd_ready, 1'b1);
      cyc();
      i_cmd_valid = 1'b0;
      check_b("e_reload", o_ld, 1'b1);
      check_i("e_ld_data", int'(o_ld_data), 'h3);
      check_b("e_dir", o_dir, 1'b0);
      cyc();
      check_i("e_cnt", int'(cnt), 'h3);
      for (int n = 0; n < 50 && o_busy; n++) cyc();
      check_b("e_finish", o_busy, 1'b0);
      check_i("e_final", int'(cnt), 0);

      // Table of one-shot runs: done offset, step count, final value
      foreach (vecs[i]) begin
         int d;
         int steps;
         int got;
         send(2'b00, vecs[i].load, vecs[i].dir, 1'b0, vecs[i].p);
         d     = 0;
         steps = 0;
         got   = -1;
         while (d < 400) begin
            if (o_done) begin
               got = d;
               break;
            end
            if (o_cnt_en) steps++;
            cyc();
            d++;
         end
         check_i("vec_done_offset", got, vecs[i].exp_done);
         check_i("vec_steps", steps, vecs[i].exp_steps);
         cyc();
         check_b("vec_idle", o_busy, 1'b0);
         check_i("vec_final", int'(cnt), vecs[i].exp_final);
      end

      // Randomized commands against the cycle-offset model
      do_reset();
      m_active = 1'b0;
      m_l      = 0;
      m_load   = 16'h0000;
      m_dir    = 1'b0;
      m_per    = 1'b0;
      m_p      = 0;
      m_clr_at = -1;
      m_irq    = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         int   d;
         int   s;
         int   mend;
         int   r;
         logic e_ld, e_clr, e_en, e_done, e_busy, e_ready, e_irq;
         logic fire;
         bit   in_done;
         e_ld = 1'b0; e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
         in_done = 1'b0;
         e_clr = (m_clr_at == t);
         e_irq = IRQ_EN ? m_irq : 1'b0;
         if (m_active) begin
            d    = t - m_l;
            s    = m_dir ? 65535 - int'(m_load) : int'(m_load);
            mend = (s == 0) ? 1 : (s - 1) * (m_p + 1) + 2;
            e_busy = 1'b1;
            if (d == 0) begin
               e_ld    = 1'b1;
               e_ready = 1'b0;
            end else if (d <= mend) begin
               e_en = (d < mend) && (((d - 1) % (m_p + 1)) == 0);
            end else begin
               e_done  = 1'b1;
               e_ready = 1'b0;
               in_done = 1'b1;
            end
         end
         check_i("rand_ctl",
                 int'({o_ld, o_clr, o_cnt_en, o_done, o_busy, o_cmd_ready, o_irq}),
                 int'({e_ld, e_clr, e_en, e_done, e_busy, e_ready, e_irq}));
         check_i("rand_latch", int'({o_dir, o_ld_data}), int'({m_dir, m_load}));

         r = int'($urandom_range(0, 9));
         i_cmd_valid    = ($urandom_range(0, 5) == 0);
         i_cmd_op       = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         i_cmd_dir      = 1'($urandom_range(0, 1));
         i_cmd_load     = i_cmd_dir ? 16'hFFFF - 16'($urandom_range(0, 10))
                                    : 16'($urandom_range(0, 10));
         i_cmd_prescale = 8'($urandom_range(0, 3));
         i_cmd_periodic = 1'($urandom_range(0, 1));
         i_irq_ack      = ($urandom_range(0, 7) == 0);
         fire = i_cmd_valid && e_ready;
         cyc();

         if (in_done) m_irq = 1'b1;
         else if (i_irq_ack) m_irq = 1'b0;
         if (fire) begin
            case (i_cmd_op)
               2'b00: begin
                  m_active = 1'b1;
                  m_l      = t + 1;
                  m_load   = i_cmd_load;
                  m_dir    = i_cmd_dir;
                  m_per    = i_cmd_periodic;
                  m_p      = int'(i_cmd_prescale);
               end
               2'b01: m_active = 1'b0;
               2'b10: begin
                  m_active = 1'b0;
                  m_clr_at = t + 1;
               end
               default: ;
            endcase
         end else if (in_done) begin
            if (m_per) m_l = t + 1;
            else       m_active = 1'b0;
         end
      end
      i_cmd_valid = 1'b0;
      i_irq_ack   = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
